// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: digit count and
// active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder.
// Non-decimal codes (10..15) show a dash so bad input is visible.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup; anything above 9 falls through to the dash.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed 7-segment driver. Snapshots the BCD digits once
// per frame, scans digits 0..3 with an anode-off guard at the start of
// each slot, and optionally blanks leading zeros.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_lzb,
    input  logic [3:0] i_bcd3,
    input  logic [3:0] i_bcd2,
    input  logic [3:0] i_bcd1,
    input  logic [3:0] i_bcd0,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [3:0] o_an,
    output logic       o_frame_tick
);

    localparam int                CNT_W    = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]        SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [3:0]        AN_DARK  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic              DP_DARK  = SEG_ACTIVE_LOW;

    // Apply segment polarity to an active-high pattern.
    function automatic logic [6:0] seg_pins(input logic [6:0] seg_hi);
        return SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    endfunction

    // Anode pins selecting exactly one digit.
    function automatic logic [3:0] an_pins(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return AN_ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_active;
    logic [3:0]       r_snap [NUM_DIGITS];
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_dp;
    logic             r_tick;

    logic             w_frame_start;
    logic             w_guard;
    logic [3:0]       w_lz;
    logic             w_digit_blank;
    logic [6:0]       w_seg_hi;

    // A frame begins on the first running edge or when the scan wraps past digit 3.
    assign w_frame_start = i_enable & (~r_active | ((r_cnt == CNT_LAST) & (r_idx == 2'd3)));
    assign w_guard       = int'(r_cnt) < BLANK_CYCLES;

    // Leading-zero chain: a digit is blankable when it and every higher digit are zero.
    assign w_lz[3]       = (r_snap[3] == 4'd0);
    assign w_lz[2]       = w_lz[3] & (r_snap[2] == 4'd0);
    assign w_lz[1]       = w_lz[2] & (r_snap[1] == 4'd0);
    assign w_lz[0]       = 1'b0;
    assign w_digit_blank = i_lzb & w_lz[r_idx];

    bcd_to_7seg u_dec (
        .i_bcd (r_snap[r_idx]),
        .o_seg (w_seg_hi)
    );

    // Slot counter and digit index; the first running edge parks at (0,0).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_active <= 1'b0;
        end else if (!r_active) begin
            r_active <= 1'b1;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Frame snapshot of the BCD inputs; held while disabled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= 4'd0;
        end else if (w_frame_start) begin
            r_snap[3] <= i_bcd3;
            r_snap[2] <= i_bcd2;
            r_snap[1] <= i_bcd1;
            r_snap[0] <= i_bcd0;
        end
    end

    // Registered display outputs, one cycle behind the (idx,cnt) state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable || !r_active) begin
            r_seg  <= SEG_DARK;
            r_an   <= AN_DARK;
            r_dp   <= DP_DARK;
            r_tick <= 1'b0;
        end else begin
            r_dp   <= DP_DARK;
            r_tick <= (r_idx == 2'd0) && (r_cnt == '0);
            if (w_guard) begin
                r_seg <= SEG_DARK;
                r_an  <= AN_DARK;
            end else begin
                r_an  <= an_pins(r_idx);
                r_seg <= w_digit_blank ? SEG_DARK : seg_pins(w_seg_hi);
            end
        end
    end

    assign o_seg        = r_seg;
    assign o_an         = r_an;
    assign o_dp         = r_dp;
    assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: directed scenarios with literal
// expectations plus randomized traffic against a frame-position model.
module tb_bcd_display_scanner;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FR = 4 * SD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic       lzb   = 1'b0;
    logic [3:0] bcd3  = 4'd1;
    logic [3:0] bcd2  = 4'd2;
    logic [3:0] bcd1  = 4'd3;
    logic [3:0] bcd0  = 4'd4;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;

    int n_vec  = 0;
    int n_err  = 0;
    bit chk_on = 1'b0;

    bcd_display_scanner #(
        .SCAN_DIV       (SD),
        .BLANK_CYCLES   (BL),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (en),
        .i_lzb        (lzb),
        .i_bcd3       (bcd3),
        .i_bcd2       (bcd2),
        .i_bcd1       (bcd1),
        .i_bcd0       (bcd0),
        .o_seg        (seg),
        .o_dp         (dp),
        .o_an         (an),
        .o_frame_tick (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec_hi(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h40;
        endcase
    endfunction

    // Model: position within the frame counted in cycles since the scan started.
    logic [3:0] m_snap [4];
    bit         m_active = 1'b0;
    int         m_n = 0;
    int         m_ph, m_d, m_c;
    bit         m_blank;
    logic [6:0] e_seg  = 7'h7F;
    logic [3:0] e_an   = 4'hF;
    logic       e_dp   = 1'b1;
    logic       e_tick = 1'b0;

    always @(posedge clk) begin
        e_dp = 1'b1;
        if (!rst_n || !en || !m_active) begin
            e_seg = 7'h7F; e_an = 4'hF; e_tick = 1'b0;
        end else begin
            m_ph   = m_n % FR;
            m_d    = m_ph / SD;
            m_c    = m_ph % SD;
            e_tick = (m_ph == 0);
            if (m_c < BL) begin
                e_seg = 7'h7F; e_an = 4'hF;
            end else begin
                e_an    = 4'hF & ~(4'b0001 << m_d);
                m_blank = lzb && (m_d > 0);
                for (int j = m_d; j < 4; j++) if (m_snap[j] != 4'd0) m_blank = 1'b0;
                e_seg = m_blank ? 7'h7F : ~dec_hi(m_snap[m_d]);
            end
        end
        if (!rst_n) begin
            m_active = 1'b0;
            for (int j = 0; j < 4; j++) m_snap[j] = 4'd0;
        end else if (!en) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1; m_n = 0;
            m_snap[0] = bcd0; m_snap[1] = bcd1; m_snap[2] = bcd2; m_snap[3] = bcd3;
        end else begin
            m_n = m_n + 1;
            if (m_n % FR == 0) begin
                m_snap[0] = bcd0; m_snap[1] = bcd1; m_snap[2] = bcd2; m_snap[3] = bcd3;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model_seg",  32'(seg),  32'(e_seg));
            cmp("model_an",   32'(an),   32'(e_an));
            cmp("model_dp",   32'(dp),   32'(e_dp));
            cmp("model_tick", 32'(tick), 32'(e_tick));
        end
    end

    task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL %s: FRAME_TICK absent after 80 cycles, required a pulse", nm);
        end
    endtask

    function automatic logic [3:0] rnd_digit();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        step(2);
        chk_on = 1'b1;
        cmp("rst_an", 32'(an), 32'h F);
        cmp("rst_seg", 32'(seg), 32'h7F);
        cmp("rst_dp", 32'(dp), 32'd1);
        cmp("rst_tick", 32'(tick), 32'd0);

        // Release with 1,2,3,4; mid-frame switch to 5,6,7,8.
        rst_n = 1'b1;
        step(1);
        cmp("rel_tick", 32'(tick), 32'd0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            case (k)
                0:  cmp("t1_tick0", 32'(tick), 32'd1);
                1:  cmp("t1_guard_an", 32'(an), 32'hF);
                2:  begin cmp("t1_an_d0", 32'(an), 32'hE); cmp("t1_seg_4", 32'(seg), 32'b0011001); end
                10: begin cmp("t1_an_d1", 32'(an), 32'hD); cmp("t1_seg_3", 32'(seg), 32'b0110000); end
                12: set_bcd(4'd5, 4'd6, 4'd7, 4'd8);
                18: begin cmp("t2_an_d2", 32'(an), 32'hB); cmp("t2_seg_old2", 32'(seg), 32'b0100100); end
                26: begin cmp("t2_an_d3", 32'(an), 32'h7); cmp("t2_seg_old1", 32'(seg), 32'b1111001); end
                32: cmp("t1_tick_period", 32'(tick), 32'd1);
                34: cmp("t2_seg_new8", 32'(seg), 32'b0000000);
                58: cmp("t2_seg_new5", 32'(seg), 32'b0010010);
                default: ;
            endcase
        end

        // Leading-zero blanking 0,0,0,7.
        set_bcd(4'd0, 4'd0, 4'd0, 4'd7); lzb = 1'b1;
        step(1); wait_tick("t3a");
        step(2);  cmp("t3_seg_7", 32'(seg), 32'b1111000); cmp("t3_an_d0", 32'(an), 32'hE);
        step(8);  cmp("t3_an_d1", 32'(an), 32'hD); cmp("t3_seg_blank1", 32'(seg), 32'h7F);
        step(16); cmp("t3_an_d3", 32'(an), 32'h7); cmp("t3_seg_blank3", 32'(seg), 32'h7F);

        // Blanking 0,4,0,0: only digit 3 dark.
        set_bcd(4'd0, 4'd4, 4'd0, 4'd0);
        step(1); wait_tick("t3b");
        step(2);  cmp("t3b_seg_d0", 32'(seg), 32'b1000000);
        step(8);  cmp("t3b_seg_d1", 32'(seg), 32'b1000000); cmp("t3b_an_d1", 32'(an), 32'hD);
        step(8);  cmp("t3b_seg_d2", 32'(seg), 32'b0011001); cmp("t3b_an_d2", 32'(an), 32'hB);
        step(8);  cmp("t3b_seg_d3", 32'(seg), 32'h7F); cmp("t3b_an_d3", 32'(an), 32'h7);

        // Dash on 0,0,0,C with LZB; LZB dropped live shows digit 3 as 0.
        set_bcd(4'd0, 4'd0, 4'd0, 4'hC);
        step(1); wait_tick("t4");
        step(2);  cmp("t4_seg_dash", 32'(seg), 32'b0111111); cmp("t4_an_d0", 32'(an), 32'hE);
        step(18); lzb = 1'b0;
        step(6);  cmp("t4_lzb_live", 32'(seg), 32'b1000000);

        // ENABLE dropped during a visible digit-2 cycle.
        wait_tick("t5");
        step(20); cmp("t5_an_d2", 32'(an), 32'hB);
        en = 1'b0; set_bcd(4'd0, 4'd0, 4'd0, 4'd3);
        step(1);  cmp("t5_dark_an", 32'(an), 32'hF); cmp("t5_dark_seg", 32'(seg), 32'h7F);
        step(3);  en = 1'b1;
        step(1);  cmp("t5_re_tick0", 32'(tick), 32'd0);
        step(1);  cmp("t5_re_tick1", 32'(tick), 32'd1);
        step(2);  cmp("t5_resnap", 32'(seg), 32'b0110000);

        // One-cycle reset mid-slot.
        step(3);  rst_n = 1'b0; set_bcd(4'd9, 4'd0, 4'd0, 4'd1);
        step(1);  cmp("t6_an", 32'(an), 32'hF); cmp("t6_seg", 32'(seg), 32'h7F); cmp("t6_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        step(1);  cmp("t6_tick0", 32'(tick), 32'd0);
        step(1);  cmp("t6_tick1", 32'(tick), 32'd1);
        step(2);  cmp("t6_seg_1", 32'(seg), 32'b1111001);
        step(24); cmp("t6_seg_9", 32'(seg), 32'b0010000); cmp("t6_an_d3", 32'(an), 32'h7);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            if (!en) begin
                if ($urandom_range(0, 3) == 0) en = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                en = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) set_bcd(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
            if ($urandom_range(0, 49) == 0) lzb = ~lzb;
        end

        step(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Downstream consumer of the four-digit BCD counter outputs. It drives a 4-digit common-anode 7-segment display by time-multiplexing the digits.
- Snapshots all four BCD digits once per scan frame, so a frame never mixes old and new digits.
- Decodes each digit to segments.
- Applies optional leading-zero blanking.
- Inserts an anode-off guard interval between digits to suppress ghosting.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (>=2); one frame = 4*SCAN_DIV cycles
BLANK_CYCLES, 500, cycles at start of each slot with all anodes off (0 <= BLANK_CYCLES < SCAN_DIV)
SEG_ACTIVE_LOW, 1, 1: segment on = 0; 0: segment on = 1
AN_ACTIVE_LOW, 1, 1: anode selected = 0; 0: anode selected = 1

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
ENABLE  in  1  display on; low forces display dark and restarts the scan
LZB  in  1  leading-zero blanking enable
BCD3  in  4  most significant digit
BCD2  in  4  digit 2
BCD1  in  4  digit 1
BCD0  in  4  least significant digit
SEG  out  7  segments {g,f,e,d,c,b,a}
DP  out  1  decimal point, always off
AN  out  4  anode selects, AN[i] drives digit i
FRAME_TICK  out  1  one-cycle pulse marking the start of each frame

Behaviour:
- Reset and ENABLE:
  - Reset=0 at a rising edge: slot counter cnt=0, digit index idx=0, snapshot=0, SEG/DP/AN all "off" per polarity parameters, FRAME_TICK=0.
  - Reset overrides everything, including mid-slot.
  - Reset has priority over ENABLE.
  - ENABLE=0 (Reset=1): same register state as reset, except the snapshot is held; outputs go "off" at the next edge.
- Scan counters:
  - When running (Reset=1, ENABLE=1), cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx increments 0,1,2,3,0.
  - cnt width is $clog2(SCAN_DIV), minimum 1.
- Snapshot:
  - Taken at every edge where the running state moves to (idx=0, cnt=0): the frame start.
  - This includes the first running edge after reset or after ENABLE rises.
  - BCD inputs are sampled only at that edge.
- Outputs are registered and lag the (idx,cnt) state by one cycle.
  - During blank cycles (cnt < BLANK_CYCLES): AN all off, SEG all off.
  - Otherwise: AN selects idx only, SEG shows the decoded digit idx from the snapshot.
- FRAME_TICK: registered, high for exactly one cycle, aligned with the output cycle for (idx=0, cnt=0).
- Decode, active-high form before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Codes 10..15 show a dash, 40 (g only); they are not blanked.
  - SEG_ACTIVE_LOW inverts the pattern.
- Leading-zero blanking, evaluated on the snapshot when LZB=1:
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit's slot keeps AN active and drives SEG all off.
  - LZB is sampled live, not snapshotted.
- BCD inputs may change on any cycle; no handshake. Changes mid-frame take effect only at the next frame start.
- BLANK_CYCLES=0: no guard interval; AN changes directly between digits.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high form).
  - NUM_DIGITS=4.
- Sub-module bcd_to_7seg: combinational; 4-bit BCD in, 7-bit active-high segments out, dash for codes > 9. Instantiated once and fed by the idx-selected snapshot digit.
- The scanner module holds the counters, snapshot, blanking logic and output registers.

Test Plan:
All cases use SCAN_DIV=8, BLANK_CYCLES=2, both polarities active-low.
1. Release Reset with ENABLE=1, BCD3..0 = 1,2,3,4:
   - FRAME_TICK pulses 1 cycle after release.
   - Output cycles 0-1: AN=1111.
   - Output cycles 2-7: AN=1110, SEG=0011001 (4).
   - Output cycles 10-15: AN=1101, SEG=0110000 (3).
   - Pattern repeats with period 32 cycles.
2. Inputs switch from 1234 to 5678 mid-frame (during the idx=1 slot):
   - Digits 2 and 3 still show 2 and 1 for the rest of that frame.
   - The next frame shows 8, 7, 6, 5.
3. LZB=1, digits 0,0,0,7:
   - Digit 3, 2 and 1 slots: AN active, SEG=1111111.
   - Digit 0 slot: SEG=1111000 (7).
   - Same LZB=1 with digits 0,4,0,0: only digit 3 is blanked; digits 1 and 0 show 0 (1000000).
4. BCD0=4'hC:
   - Digit 0 slot shows SEG=0111111 (dash).
   - With LZB=1 and digits 0,0,0,C, digit 0 is not blanked.
5. ENABLE dropped during an idx=2 visible cycle:
   - Next output cycle: AN=1111, SEG=1111111.
   - On re-enable: FRAME_TICK pulses, the scan restarts at digit 0, and a new snapshot is taken.
6. Reset=0 asserted mid-slot for 1 cycle:
   - Next output cycle: all outputs off.
   - After release: the scan restarts at idx=0 and the snapshot is re-sampled.
